// File: rtl/pdn_rail_sequencer_if.sv
// Rail sequencer bus: request, per-rail power-good/enable and status.
interface pdn_rail_sequencer_if #(
  parameter int NUM_RAILS = 8
);
  logic                 pwr_on_req;
  logic [NUM_RAILS-1:0] rail_pg;
  logic [NUM_RAILS-1:0] rail_en;
  logic                 seq_busy;
  logic                 all_good;
  logic                 fault;
  logic [3:0]           fault_rail;

  modport slave (
    input  pwr_on_req, rail_pg,
    output rail_en, seq_busy, all_good, fault, fault_rail
  );

  modport master (
    output pwr_on_req, rail_pg,
    input  rail_en, seq_busy, all_good, fault, fault_rail
  );
endinterface

// File: rtl/pdn_rail_sequencer.sv
// Ordered power-up/power-down sequencer for NUM_RAILS supply rails with
// per-rail power-good timeout, settle hold and fault latching.
module pdn_rail_sequencer #(
  parameter int NUM_RAILS      = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  pdn_rail_sequencer_if.slave bus
);
  localparam int MAXC = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  localparam logic [TW-1:0]        SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]        TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]           IDX_LAST    = 4'(NUM_RAILS - 1);
  localparam logic [NUM_RAILS-1:0] ONE         = {{(NUM_RAILS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP,
    S_SETTLE,
    S_UP,
    S_DOWN,
    S_FAULT
  } state_t;

  state_t               r_state, w_state;
  logic [3:0]           r_idx, w_idx;
  logic [TW-1:0]        r_timer, w_timer;
  logic [NUM_RAILS-1:0] r_rail_en, w_rail_en;
  logic [3:0]           r_fault_rail, w_fault_rail;

  logic [NUM_RAILS-1:0] w_onehot;
  logic                 w_pg_cur;
  logic [3:0]           w_low_fail;

  // Register all sequencer state; reset drops every rail at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_timer      <= '0;
      r_rail_en    <= '0;
      r_fault_rail <= '0;
    end else begin
      r_state      <= w_state;
      r_idx        <= w_idx;
      r_timer      <= w_timer;
      r_rail_en    <= w_rail_en;
      r_fault_rail <= w_fault_rail;
    end
  end

  // Lowest-index rail reporting loss of power-good (used from UP).
  always_comb begin
    logic found;
    found      = 1'b0;
    w_low_fail = '0;
    for (int unsigned i = 0; i < NUM_RAILS; i++) begin
      if (!found && !bus.rail_pg[i]) begin
        found      = 1'b1;
        w_low_fail = 4'(i);
      end
    end
  end

  // Next-state logic; within RAMP/SETTLE fault beats abort beats progress.
  always_comb begin
    w_state      = r_state;
    w_idx        = r_idx;
    w_timer      = r_timer;
    w_rail_en    = r_rail_en;
    w_fault_rail = r_fault_rail;
    w_onehot     = ONE << r_idx;
    w_pg_cur     = |(bus.rail_pg & w_onehot);

    case (r_state)
      S_IDLE: begin
        if (bus.pwr_on_req) begin
          w_state   = S_RAMP;
          w_idx     = '0;
          w_timer   = '0;
          w_rail_en = ONE;
        end
      end
      S_RAMP: begin
        if (!w_pg_cur && r_timer == TO_LAST) begin
          w_state      = S_FAULT;
          w_rail_en    = '0;
          w_fault_rail = r_idx;
        end else if (!bus.pwr_on_req) begin
          w_state   = S_DOWN;
          w_timer   = '0;
          w_rail_en = r_rail_en & ~w_onehot;
        end else if (w_pg_cur) begin
          w_state = S_SETTLE;
          w_timer = '0;
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end
      S_SETTLE: begin
        if (!w_pg_cur) begin
          w_state      = S_FAULT;
          w_rail_en    = '0;
          w_fault_rail = r_idx;
        end else if (!bus.pwr_on_req) begin
          w_state   = S_DOWN;
          w_timer   = '0;
          w_rail_en = r_rail_en & ~w_onehot;
        end else if (r_timer == SETTLE_LAST) begin
          w_timer = '0;
          if (r_idx == IDX_LAST) begin
            w_state = S_UP;
          end else begin
            w_state   = S_RAMP;
            w_idx     = r_idx + 1'b1;
            w_rail_en = r_rail_en | (w_onehot << 1);
          end
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end
      S_UP: begin
        if (!(&bus.rail_pg)) begin
          w_state      = S_FAULT;
          w_rail_en    = '0;
          w_fault_rail = w_low_fail;
        end else if (!bus.pwr_on_req) begin
          w_state   = S_DOWN;
          w_idx     = IDX_LAST;
          w_timer   = '0;
          w_rail_en = r_rail_en & ~(ONE << IDX_LAST);
        end
      end
      S_DOWN: begin
        if (r_timer == SETTLE_LAST) begin
          w_timer = '0;
          if (r_idx == '0) begin
            w_state = S_IDLE;
          end else begin
            w_idx     = r_idx - 1'b1;
            w_rail_en = r_rail_en & ~(w_onehot >> 1);
          end
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end
      S_FAULT: begin
        if (!bus.pwr_on_req) begin
          w_state = S_IDLE;
          w_idx   = '0;
          w_timer = '0;
        end
      end
      default: begin
        w_state   = S_IDLE;
        w_idx     = '0;
        w_timer   = '0;
        w_rail_en = '0;
      end
    endcase
  end

  assign bus.rail_en    = r_rail_en;
  assign bus.fault_rail = r_fault_rail;
  assign bus.seq_busy   = (r_state == S_RAMP) || (r_state == S_SETTLE) || (r_state == S_DOWN);
  assign bus.all_good   = (r_state == S_UP);
  assign bus.fault      = (r_state == S_FAULT);
endmodule

// File: tb/tb_pdn_rail_sequencer.sv
// Directed bench for pdn_rail_sequencer with NUM_RAILS=4, SETTLE=4, TIMEOUT=8.
module tb_pdn_rail_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pdn_rail_sequencer_if #(.NUM_RAILS(4)) bus ();

  pdn_rail_sequencer #(
    .NUM_RAILS      (4),
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Power-good source: either rail_en echoed one cycle late (masked) or manual.
  logic       echo_on = 1'b1;
  logic [3:0] pg_mask = 4'hF;
  logic [3:0] pg_man  = 4'h0;
  logic [3:0] r_echo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_echo <= '0;
    else     r_echo <= bus.rail_en;
  end

  always_comb bus.rail_pg = echo_on ? (r_echo & pg_mask) : pg_man;

  typedef struct {
    logic       req;
    logic [3:0] pg;
    logic [3:0] en;
    logic       busy;
    logic       good;
    logic       flt;
    logic [3:0] fr;
  } vec_t;

  vec_t tbl [21];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Packed view {rail_en, seq_busy, all_good, fault, fault_rail}.
  function automatic logic [31:0] outv();
    return {21'd0, bus.rail_en, bus.seq_busy, bus.all_good, bus.fault, bus.fault_rail};
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] en, input logic b, input logic g,
                                     input logic f, input logic [3:0] fr);
    return {21'd0, en, b, g, f, fr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.pwr_on_req = 1'b0;
    echo_on = 1'b1;
    pg_mask = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] een;
    tbl = '{
      '{1'b1, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 4'd0},
      '{1'b1, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 4'd0},
      '{1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 4'd0},
      '{1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 4'd0},
      '{1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 4'd0},
      '{1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 4'd0},
      '{1'b1, 4'b0001, 4'b0011, 1'b1, 1'b0, 1'b0, 4'd0},
      '{1'b1, 4'b0001, 4'b0011, 1'b1, 1'b0, 1'b0, 4'd0},
      '{1'b1, 4'b0011, 4'b0011, 1'b1, 1'b0, 1'b0, 4'd0},
      '{1'b1, 4'b0011, 4'b0011, 1'b1, 1'b0, 1'b0, 4'd0},
      '{1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 4'd1},
      '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'd1},
      '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd1},
      '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd1},
      '{1'b1, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 4'd1},
      '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd1},
      '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd1},
      '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd1},
      '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd1},
      '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd1},
      '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd1}
    };

    bus.pwr_on_req = 1'b0;
    do_reset();
    chk("reset_state", outv(), '0);

    // Table: manual power-good, pg loss in SETTLE, fault hold/exit, abort in RAMP.
    echo_on = 1'b0;
    for (int i = 0; i < 21; i++) begin
      bus.pwr_on_req = tbl[i].req;
      pg_man = tbl[i].pg;
      step();
      chk($sformatf("tbl[%0d]", i), outv(),
          mk(tbl[i].en, tbl[i].busy, tbl[i].good, tbl[i].flt, tbl[i].fr));
    end

    // Full power-up with echoed power-good, then ordered power-down.
    do_reset();
    bus.pwr_on_req = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      een = (k < 6) ? 4'b0001 : (k < 12) ? 4'b0011 : (k < 18) ? 4'b0111 : 4'b1111;
      chk($sformatf("up[%0d]", k), outv(), mk(een, k < 24, k >= 24, 1'b0, 4'd0));
    end
    bus.pwr_on_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      een = (k < 4) ? 4'b0111 : (k < 8) ? 4'b0011 : (k < 12) ? 4'b0001 : 4'b0000;
      chk($sformatf("down[%0d]", k), outv(), mk(een, k < 16, 1'b0, 1'b0, 4'd0));
    end

    // Power-good glitch in UP on rail 1.
    do_reset();
    bus.pwr_on_req = 1'b1;
    repeat (25) step();
    chk("up_reached", outv(), mk(4'b1111, 1'b0, 1'b1, 1'b0, 4'd0));
    pg_man = 4'b1101;
    echo_on = 1'b0;
    step();
    chk("up_glitch_fault", outv(), mk(4'b0000, 1'b0, 1'b0, 1'b1, 4'd1));
    pg_man = 4'b1111;
    step();
    chk("fault_hold", outv(), mk(4'b0000, 1'b0, 1'b0, 1'b1, 4'd1));
    bus.pwr_on_req = 1'b0;
    step();
    chk("fault_exit", outv(), mk(4'b0000, 1'b0, 1'b0, 1'b0, 4'd1));

    // Two rails failing in UP: lowest index is reported.
    do_reset();
    bus.pwr_on_req = 1'b1;
    repeat (25) step();
    pg_man = 4'b0101;
    echo_on = 1'b0;
    step();
    chk("up_lowest_fail", outv(), mk(4'b0000, 1'b0, 1'b0, 1'b1, 4'd1));

    // Rail 2 never reports power-good: timeout after 8 cycles in RAMP.
    do_reset();
    pg_mask = 4'b1011;
    bus.pwr_on_req = 1'b1;
    repeat (20) step();
    chk("timeout_pre", outv(), mk(4'b0111, 1'b1, 1'b0, 1'b0, 4'd0));
    step();
    chk("timeout_fault", outv(), mk(4'b0000, 1'b0, 1'b0, 1'b1, 4'd2));
    bus.pwr_on_req = 1'b0;
    step();
    chk("timeout_exit", outv(), mk(4'b0000, 1'b0, 1'b0, 1'b0, 4'd2));

    // Timeout and abort on the same edge: fault wins.
    do_reset();
    pg_mask = 4'b1011;
    bus.pwr_on_req = 1'b1;
    repeat (20) step();
    bus.pwr_on_req = 1'b0;
    step();
    chk("fault_over_abort", outv(), mk(4'b0000, 1'b0, 1'b0, 1'b1, 4'd2));
    step();
    chk("fault_over_abort_exit", outv(), mk(4'b0000, 1'b0, 1'b0, 1'b0, 4'd2));

    // Asynchronous reset mid-ramp with fault_rail still holding 2.
    pg_mask = 4'hF;
    bus.pwr_on_req = 1'b1;
    repeat (14) step();
    chk("pre_async_rst", outv(), mk(4'b0111, 1'b1, 1'b0, 1'b0, 4'd2));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", outv(), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_released_idle", outv(), '0);
    step();
    chk("restart_after_rst", outv(), mk(4'b0001, 1'b1, 1'b0, 1'b0, 4'd0));

    // Abort in SETTLE at rail 1; re-request during DOWN is ignored until IDLE.
    do_reset();
    bus.pwr_on_req = 1'b1;
    repeat (10) step();
    chk("settle_idx1", outv(), mk(4'b0011, 1'b1, 1'b0, 1'b0, 4'd0));
    bus.pwr_on_req = 1'b0;
    step();
    chk("abort_first", outv(), mk(4'b0001, 1'b1, 1'b0, 1'b0, 4'd0));
    bus.pwr_on_req = 1'b1;
    repeat (3) step();
    chk("abort_hold", outv(), mk(4'b0001, 1'b1, 1'b0, 1'b0, 4'd0));
    step();
    chk("abort_second", outv(), mk(4'b0000, 1'b1, 1'b0, 1'b0, 4'd0));
    repeat (3) step();
    chk("abort_down_tail", outv(), mk(4'b0000, 1'b1, 1'b0, 1'b0, 4'd0));
    step();
    chk("abort_idle", outv(), mk(4'b0000, 1'b0, 1'b0, 1'b0, 4'd0));
    step();
    chk("rerequest", outv(), mk(4'b0001, 1'b1, 1'b0, 1'b0, 4'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pdn_rail_sequencer.md
PDN_RAIL_SEQUENCER -- requirements
Module: pdn_rail_sequencer

Interface
REQ-001 Parameter NUM_RAILS, default 8, number of sequenced supply rails (2..16).
REQ-002 Parameter SETTLE_CYCLES, default 16, hold time per rail after power-good, and gap between rails on power-down (>=1).
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum cycles to wait for a rail's power-good (>=2).
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pwr_on_req  input  1  level request: 1 = power rails up, 0 = power rails down.
REQ-007 rail_pg  input  NUM_RAILS  per-rail power-good, synchronous to clk.
REQ-008 rail_en  output  NUM_RAILS  per-rail enable, registered.
REQ-009 seq_busy  output  1  high in RAMP, SETTLE and DOWN.
REQ-010 all_good  output  1  high only in UP.
REQ-011 fault  output  1  high only in FAULT.
REQ-012 fault_rail  output  4  index of the rail that caused the fault; held until the next fault.

Function
REQ-013 FSM states: IDLE, RAMP, SETTLE, UP, DOWN, FAULT; rail index idx (4 bits); timer wide enough for max(SETTLE_CYCLES, TIMEOUT_CYCLES).
REQ-014 IDLE, pwr_on_req=1 at an edge: same edge sets idx=0, rail_en[0]=1, timer=0, state RAMP; rail_en[0] is visible 1 cycle after request sampled.
REQ-015 RAMP, rail_pg[idx]=1: state SETTLE, timer=0.
REQ-016 RAMP, rail_pg[idx]=0: timer increments; on the edge where timer==TIMEOUT_CYCLES-1 -> FAULT.
REQ-017 SETTLE: timer increments each cycle; rail_pg[idx]=0 on any cycle -> FAULT.
REQ-018 SETTLE, timer==SETTLE_CYCLES-1: if idx==NUM_RAILS-1 -> UP; else idx+1, rail_en[idx+1]=1, timer=0, RAMP.
REQ-019 Rails enable strictly in ascending index order; rail_en is always a contiguous low-order mask (thermometer code) outside FAULT.
REQ-020 UP: any rail_pg bit 0 -> FAULT, fault_rail = lowest failing index.
REQ-021 UP, pwr_on_req=0: state DOWN, idx=NUM_RAILS-1, timer=0.
REQ-022 RAMP or SETTLE, pwr_on_req=0 (abort): state DOWN at current idx, timer=0; the partially enabled rail is included in the power-down.
REQ-023 DOWN: same edge as entry clears rail_en[idx]; after SETTLE_CYCLES cycles, if idx==0 -> IDLE, else idx-1 and clear rail_en[idx-1]; descending order, one rail per SETTLE_CYCLES.
REQ-024 DOWN ignores rail_pg and pwr_on_req; re-request is honoured only after returning to IDLE.
REQ-025 Entering FAULT clears all rail_en on the same edge, latches fault_rail=idx (or per REQ-020).
REQ-026 FAULT exits to IDLE on the first edge with pwr_on_req=0; while pwr_on_req stays 1, FAULT holds indefinitely.
REQ-027 Precedence in RAMP/SETTLE within one cycle: fault (timeout/pg loss) over abort (pwr_on_req=0) over normal progress.
REQ-028 Outputs seq_busy, all_good and fault are decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-029 rst=1 forces IDLE, rail_en=0, idx=0, timer=0, fault_rail=0, seq_busy=0, all_good=0, fault=0, immediately and asynchronously.
REQ-030 rst asserted mid-sequence drops all rail_en without ordered power-down; after release the block restarts from IDLE and needs a new pwr_on_req sample.

Verification (NUM_RAILS=4, SETTLE_CYCLES=4, TIMEOUT_CYCLES=8)
REQ-031 Power-up, rail_pg echoes rail_en one cycle late -> rail_en steps 0001, 0011, 0111, 1111 with each step 6 cycles apart; all_good=1 thereafter; seq_busy=1 throughout the ramp.
REQ-032 From UP, drop pwr_on_req -> rail_en steps 0111, 0011, 0001, 0000 with each step 4 cycles apart; then IDLE, seq_busy=0.
REQ-033 rail_pg[2] held 0 -> after 8 cycles in RAMP at idx 2: rail_en=0000, fault=1, fault_rail=2; pwr_on_req=0 -> IDLE next cycle, fault=0.
REQ-034 In UP, pulse rail_pg[1]=0 for 1 cycle -> FAULT, rail_en=0000, fault_rail=1.
REQ-035 Drop pwr_on_req while in SETTLE at idx 1 (rail_en=0011) -> 0001 on the next edge, 0000 4 cycles later, then IDLE; re-raising pwr_on_req during DOWN has no effect until IDLE.
REQ-036 Assert rst while rail_en=0111 -> rail_en=0000 asynchronously; all outputs at reset values.
